// File: rtl/phy_mdio_resp.sv
// Clause-22 MDIO responder: decodes management frames on mdc and serves a
// small PHY register file (control, status, ID, advertisement).
module phy_mdio_resp #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHY_ID1  = 16'h0022,
    parameter logic [15:0] PHY_ID2  = 16'h1550
) (
    input  logic        mdc,
    input  logic        rst_n,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        link_up,
    output logic [15:0] ctrl_reg,
    output logic        wr_strobe,
    output logic [4:0]  wr_reg_add
);

    localparam logic [15:0] CTRL_DEFAULT = 16'h3100;
    localparam logic [15:0] ADV_DEFAULT  = 16'h01E1;
    localparam logic [15:0] CTRL_WR_MASK = 16'h7F80;
    localparam logic [15:0] STATUS_BASE  = 16'h7809;
    localparam logic [5:0]  PRE_FULL     = 6'd32;

    typedef enum logic [3:0] {
        IDLE,
        ST,
        OP,
        PHYAD,
        REGAD,
        TA,
        WDATA,
        RDATA,
        SKIP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_cnt_nxt;
    logic [5:0]  pre_cnt;
    logic [5:0]  pre_cnt_nxt;
    logic        op_read;
    logic        op_read_nxt;
    logic [4:0]  phyad;
    logic [4:0]  phyad_nxt;
    logic [4:0]  regad;
    logic [4:0]  regad_nxt;
    logic [15:0] shift;
    logic [15:0] shift_nxt;
    logic        mdio_o_nxt;
    logic        mdio_oe_nxt;
    logic [15:0] ctrl_nxt;
    logic [15:0] adv;
    logic [15:0] adv_nxt;
    logic        wr_strobe_nxt;
    logic [4:0]  wr_reg_add_nxt;

    logic [15:0] rd_data;
    logic [15:0] status_val;
    logic [15:0] wr_value;
    logic        addr_match;

    always_comb begin
        status_val = STATUS_BASE | {10'd0, link_up, 2'd0, link_up, 2'd0};
        case (regad)
            5'd0:    rd_data = ctrl_reg;
            5'd1:    rd_data = status_val;
            5'd2:    rd_data = PHY_ID1;
            5'd3:    rd_data = PHY_ID2;
            5'd4:    rd_data = adv;
            default: rd_data = 16'h0000;
        endcase
    end

    // Broadcast address is accepted for writes only so reads never collide
    always_comb begin
        wr_value = {shift[14:0], mdio_i};
        if (op_read) begin
            addr_match = (phyad == PHY_ADDR);
        end else begin
            addr_match = (phyad == PHY_ADDR) || (phyad == 5'd0);
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt + 5'd1;
        pre_cnt_nxt    = 6'd0;
        op_read_nxt    = op_read;
        phyad_nxt      = phyad;
        regad_nxt      = regad;
        shift_nxt      = shift;
        mdio_o_nxt     = mdio_o;
        mdio_oe_nxt    = mdio_oe;
        ctrl_nxt       = ctrl_reg & ~16'h0200;
        adv_nxt        = adv;
        wr_strobe_nxt  = 1'b0;
        wr_reg_add_nxt = wr_reg_add;

        case (state)
            IDLE: begin
                bit_cnt_nxt = 5'd0;
                if (mdio_i) begin
                    pre_cnt_nxt = (pre_cnt == PRE_FULL) ? PRE_FULL : pre_cnt + 6'd1;
                end else if (pre_cnt == PRE_FULL) begin
                    state_nxt = ST;
                end
            end
            ST: begin
                bit_cnt_nxt = 5'd0;
                state_nxt   = mdio_i ? OP : IDLE;
            end
            OP: begin
                if (bit_cnt == 5'd0) begin
                    op_read_nxt = mdio_i;
                end else if (op_read != mdio_i) begin
                    bit_cnt_nxt = 5'd0;
                    state_nxt   = PHYAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PHYAD: begin
                phyad_nxt = {phyad[3:0], mdio_i};
                if (bit_cnt == 5'd4) begin
                    bit_cnt_nxt = 5'd0;
                    state_nxt   = REGAD;
                end
            end
            REGAD: begin
                regad_nxt = {regad[3:0], mdio_i};
                if (bit_cnt == 5'd4) begin
                    bit_cnt_nxt = 5'd0;
                    state_nxt   = addr_match ? TA : SKIP;
                end
            end
            // Read data is captured on the first turnaround edge
            TA: begin
                if (bit_cnt == 5'd0) begin
                    if (op_read) begin
                        mdio_oe_nxt = 1'b1;
                        mdio_o_nxt  = 1'b0;
                        shift_nxt   = rd_data;
                    end
                end else begin
                    bit_cnt_nxt = 5'd0;
                    if (op_read) begin
                        mdio_o_nxt = shift[15];
                        shift_nxt  = {shift[14:0], 1'b0};
                        state_nxt  = RDATA;
                    end else begin
                        state_nxt = WDATA;
                    end
                end
            end
            RDATA: begin
                mdio_o_nxt = shift[15];
                shift_nxt  = {shift[14:0], 1'b0};
                if (bit_cnt == 5'd15) begin
                    mdio_o_nxt  = 1'b0;
                    mdio_oe_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            WDATA: begin
                shift_nxt = wr_value;
                if (bit_cnt == 5'd15) begin
                    wr_strobe_nxt  = 1'b1;
                    wr_reg_add_nxt = regad;
                    state_nxt      = IDLE;
                    if (regad == 5'd0) begin
                        if (wr_value[15]) begin
                            ctrl_nxt = CTRL_DEFAULT;
                            adv_nxt  = ADV_DEFAULT;
                        end else begin
                            ctrl_nxt = wr_value & CTRL_WR_MASK;
                        end
                    end else if (regad == 5'd4) begin
                        adv_nxt = wr_value;
                    end
                end
            end
            SKIP: begin
                if (bit_cnt == 5'd17) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge mdc) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge mdc) begin
        if (!rst_n) begin
            bit_cnt    <= 5'd0;
            pre_cnt    <= 6'd0;
            op_read    <= 1'b0;
            phyad      <= 5'd0;
            regad      <= 5'd0;
            shift      <= 16'h0000;
            mdio_o     <= 1'b0;
            mdio_oe    <= 1'b0;
            ctrl_reg   <= CTRL_DEFAULT;
            adv        <= ADV_DEFAULT;
            wr_strobe  <= 1'b0;
            wr_reg_add <= 5'd0;
        end else begin
            bit_cnt    <= bit_cnt_nxt;
            pre_cnt    <= pre_cnt_nxt;
            op_read    <= op_read_nxt;
            phyad      <= phyad_nxt;
            regad      <= regad_nxt;
            shift      <= shift_nxt;
            mdio_o     <= mdio_o_nxt;
            mdio_oe    <= mdio_oe_nxt;
            ctrl_reg   <= ctrl_nxt;
            adv        <= adv_nxt;
            wr_strobe  <= wr_strobe_nxt;
            wr_reg_add <= wr_reg_add_nxt;
        end
    end

endmodule

// File: tb/tb_phy_mdio_resp.sv
// Scoreboard bench for phy_mdio_resp: frames are queued with their expected
// response and a monitor checks each read drive or write strobe against it.
module tb_phy_mdio_resp;

    localparam int K_NONE  = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;
    localparam int K_ABORT = 3;

    typedef struct {
        int          kind;
        logic [4:0]  reg_add;
        logic [15:0] data;
        logic [15:0] ctrl;
        logic [15:0] ctrl_next;
        int          e_cyc;
    } exp_t;

    logic        mdc;
    logic        rst_n;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic        link_up;
    logic [15:0] ctrl_reg;
    logic        wr_strobe;
    logic [4:0]  wr_reg_add;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_fail;
    logic oe_any;

    phy_mdio_resp #(
        .PHY_ADDR(5'd1),
        .PHY_ID1 (16'h0022),
        .PHY_ID2 (16'h1550)
    ) dut (
        .mdc       (mdc),
        .rst_n     (rst_n),
        .mdio_i    (mdio_i),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .link_up   (link_up),
        .ctrl_reg  (ctrl_reg),
        .wr_strobe (wr_strobe),
        .wr_reg_add(wr_reg_add)
    );

    initial mdc = 1'b0;
    always #5 mdc = ~mdc;

    initial cyc = 0;
    always @(posedge mdc) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One frame, bit k sampled at posedge cyc0+k; line idles high after the
    // address on reads (master releases, pull-up holds it at 1).
    task automatic apply_stimulus(input int pre_len, input logic [1:0] op,
                                  input logic [4:0] phyad, input logic [4:0] regad,
                                  input logic [15:0] data, input int kind,
                                  input logic [15:0] exp_data, input logic [15:0] exp_ctrl,
                                  input logic [15:0] exp_ctrl_next);
        logic q[$];
        exp_t e;
        int   c0;
        q = {};
        for (int i = 0; i < pre_len; i++) q.push_back(1'b1);
        q.push_back(1'b0);
        q.push_back(1'b1);
        q.push_back(op[1]);
        q.push_back(op[0]);
        for (int i = 4; i >= 0; i--) q.push_back(phyad[i]);
        for (int i = 4; i >= 0; i--) q.push_back(regad[i]);
        if (op == 2'b01) begin
            q.push_back(1'b1);
            q.push_back(1'b0);
            for (int i = 15; i >= 0; i--) q.push_back(data[i]);
        end else begin
            for (int i = 0; i < 18; i++) q.push_back(1'b1);
        end
        c0 = cyc;
        e.kind      = kind;
        e.reg_add   = regad;
        e.data      = exp_data;
        e.ctrl      = exp_ctrl;
        e.ctrl_next = exp_ctrl_next;
        e.e_cyc     = c0 + pre_len + 14;
        if (kind != K_NONE) sb.push_back(e);
        oe_any = 1'b0;
        for (int k = 1; k <= q.size(); k++) begin
            if (kind == K_ABORT && c0 + k == e.e_cyc + 9) rst_n = 1'b0;
            mdio_i = q[k-1];
            @(negedge mdc);
            oe_any = oe_any | mdio_oe;
            if (!rst_n) begin
                rst_n = 1'b1;
                break;
            end
        end
        mdio_i = 1'b1;
        if (kind == K_NONE) check_output("no_drive", {31'd0, oe_any}, 32'd0);
    endtask

    // Monitor: reacts to a rising mdio_oe or a write strobe
    initial begin : monitor
        exp_t        e;
        logic        prev_oe;
        logic [15:0] got;
        prev_oe = 1'b0;
        forever begin
            @(negedge mdc);
            if (rst_n && mdio_oe && !prev_oe) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_drive", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("drive_kind", (e.kind == K_READ || e.kind == K_ABORT) ? 32'd1 : 32'd0, 32'd1);
                    check_output("oe_rise_cyc", cyc, e.e_cyc + 1);
                    check_output("ta2_bit", {31'd0, mdio_o}, 32'd0);
                    if (e.kind == K_ABORT) begin
                        for (int i = 0; i < 25 && mdio_oe; i++) @(negedge mdc);
                        check_output("abort_oe_drop_cyc", cyc, e.e_cyc + 9);
                        check_output("abort_oe", {31'd0, mdio_oe}, 32'd0);
                    end else begin
                        got = 16'h0000;
                        for (int i = 15; i >= 0; i--) begin
                            @(negedge mdc);
                            got[i] = mdio_o;
                            if (!mdio_oe) check_output("oe_held", 32'd0, 32'd1);
                        end
                        check_output($sformatf("rd_data_reg%0d", e.reg_add), {16'd0, got}, {16'd0, e.data});
                        @(negedge mdc);
                        check_output("oe_release", {31'd0, mdio_oe}, 32'd0);
                        check_output("oe_release_cyc", cyc, e.e_cyc + 18);
                    end
                end
            end else if (rst_n && wr_strobe) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("strobe_kind", e.kind, K_WRITE);
                    check_output("strobe_cyc", cyc, e.e_cyc + 18);
                    check_output("wr_reg_add", {27'd0, wr_reg_add}, {27'd0, e.reg_add});
                    check_output("ctrl_at_commit", {16'd0, ctrl_reg}, {16'd0, e.ctrl});
                    @(negedge mdc);
                    check_output("strobe_width", {31'd0, wr_strobe}, 32'd0);
                    check_output("ctrl_after_commit", {16'd0, ctrl_reg}, {16'd0, e.ctrl_next});
                end
            end
            prev_oe = mdio_oe;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        mdio_i   = 1'b1;
        link_up  = 1'b0;
        oe_any   = 1'b0;
        repeat (3) @(negedge mdc);
        check_output("rst_ctrl_reg", {16'd0, ctrl_reg}, 32'h3100);
        check_output("rst_mdio_oe", {31'd0, mdio_oe}, 32'd0);
        check_output("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
        check_output("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check_output("rst_wr_reg_add", {27'd0, wr_reg_add}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge mdc);

        apply_stimulus(32, 2'b10, 5'd1, 5'd0, 16'h0, K_READ,  16'h3100, 16'h0, 16'h0);
        apply_stimulus(32, 2'b01, 5'd0, 5'd4, 16'h05E1, K_WRITE, 16'h0, 16'h3100, 16'h3100);
        apply_stimulus(32, 2'b10, 5'd1, 5'd4, 16'h0, K_READ,  16'h05E1, 16'h0, 16'h0);
        link_up = 1'b1;
        apply_stimulus(32, 2'b10, 5'd1, 5'd1, 16'h0, K_READ,  16'h782D, 16'h0, 16'h0);
        link_up = 1'b0;
        apply_stimulus(32, 2'b10, 5'd1, 5'd1, 16'h0, K_READ,  16'h7809, 16'h0, 16'h0);
        apply_stimulus(32, 2'b10, 5'd3, 5'd2, 16'h0, K_NONE,  16'h0, 16'h0, 16'h0);
        apply_stimulus(32, 2'b10, 5'd0, 5'd2, 16'h0, K_NONE,  16'h0, 16'h0, 16'h0);
        apply_stimulus(32, 2'b10, 5'd1, 5'd2, 16'h0, K_READ,  16'h0022, 16'h0, 16'h0);
        apply_stimulus(31, 2'b10, 5'd1, 5'd0, 16'h0, K_NONE,  16'h0, 16'h0, 16'h0);
        apply_stimulus(32, 2'b10, 5'd1, 5'd0, 16'h0, K_READ,  16'h3100, 16'h0, 16'h0);
        apply_stimulus(32, 2'b11, 5'd1, 5'd3, 16'h0, K_NONE,  16'h0, 16'h0, 16'h0);
        apply_stimulus(32, 2'b10, 5'd1, 5'd3, 16'h0, K_READ,  16'h1550, 16'h0, 16'h0);
        apply_stimulus(32, 2'b01, 5'd1, 5'd0, 16'h0100, K_WRITE, 16'h0, 16'h0100, 16'h0100);
        apply_stimulus(32, 2'b01, 5'd1, 5'd0, 16'h8000, K_WRITE, 16'h0, 16'h3100, 16'h3100);
        apply_stimulus(32, 2'b10, 5'd1, 5'd4, 16'h0, K_READ,  16'h01E1, 16'h0, 16'h0);
        apply_stimulus(32, 2'b01, 5'd1, 5'd0, 16'h3300, K_WRITE, 16'h0, 16'h3300, 16'h3100);
        apply_stimulus(32, 2'b01, 5'd1, 5'd0, 16'h007F, K_WRITE, 16'h0, 16'h0000, 16'h0000);
        apply_stimulus(32, 2'b10, 5'd1, 5'd0, 16'h0, K_READ,  16'h0000, 16'h0, 16'h0);
        apply_stimulus(32, 2'b01, 5'd1, 5'd9, 16'hABCD, K_WRITE, 16'h0, 16'h0000, 16'h0000);
        apply_stimulus(32, 2'b10, 5'd1, 5'd9, 16'h0, K_READ,  16'h0000, 16'h0, 16'h0);
        apply_stimulus(32, 2'b10, 5'd1, 5'd0, 16'h0, K_ABORT, 16'h0, 16'h0, 16'h0);
        check_output("ctrl_after_abort_reset", {16'd0, ctrl_reg}, 32'h3100);
        apply_stimulus(32, 2'b10, 5'd1, 5'd0, 16'h0, K_READ,  16'h3100, 16'h0, 16'h0);

        repeat (5) @(negedge mdc);
        check_output("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
